// File: rtl/acc14.sv
// Saturating signed frame accumulator: sums iLen terms, result valid the cycle after the last term.
// Valid/ready on both sides; no terms are taken while a result waits for downstream (oReady).
module acc14 #(
    parameter int IWID = 8,
    parameter int OWID = 14,
    parameter int CWID = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CWID-1:0] iLen,
    input  logic            iValid,
    input  logic [IWID-1:0] iData,
    output logic            iReady,
    output logic            oValid,
    output logic [OWID-1:0] oData,
    output logic            oSat,
    input  logic            oReady
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [CWID-1:0] CNT_ONE = CWID'(1);
    localparam logic [OWID-1:0] ACC_MAX = {1'b0, {(OWID-1){1'b1}}};
    localparam logic [OWID-1:0] ACC_MIN = {1'b1, {(OWID-1){1'b0}}};

    logic [1:0]      state;
    logic [OWID-1:0] acc;
    logic [CWID-1:0] cnt;
    logic [CWID-1:0] len;
    logic            sat_flag;

    logic            in_xfer;
    logic [OWID:0]   term_ext;
    logic [OWID:0]   sum_ext;
    logic [OWID-1:0] sum_sat;
    logic            sum_clamp;
    logic [CWID-1:0] cnt_nxt;
    logic [CWID-1:0] eff_len;

    assign iReady  = !rst_n && (state == S_IDLE || state == S_ACC);
    assign oValid  = !rst_n && (state == S_OUT);
    assign oData   = acc;
    assign oSat    = sat_flag;
    assign in_xfer = iValid && iReady;

    // One extra bit of headroom holds the exact sum before clamping to the rails.
    assign term_ext = {{(OWID + 1 - IWID){iData[IWID-1]}}, iData};
    assign sum_ext  = {acc[OWID-1], acc} + term_ext;
    assign cnt_nxt  = cnt + CNT_ONE;
    assign eff_len  = (iLen == '0) ? CNT_ONE : iLen;

    always_comb begin
        sum_sat   = sum_ext[OWID-1:0];
        sum_clamp = 1'b0;
        if (sum_ext[OWID] != sum_ext[OWID-1]) begin
            sum_clamp = 1'b1;
            sum_sat   = sum_ext[OWID] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            len      <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_xfer) begin
                        acc      <= term_ext[OWID-1:0];
                        cnt      <= CNT_ONE;
                        len      <= eff_len;
                        sat_flag <= 1'b0;
                        state    <= (eff_len == CNT_ONE) ? S_OUT : S_ACC;
                    end
                end
                S_ACC: begin
                    if (in_xfer) begin
                        acc <= sum_sat;
                        cnt <= cnt_nxt;
                        if (sum_clamp) begin
                            sat_flag <= 1'b1;
                        end
                        if (cnt_nxt == len) begin
                            state <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (oReady) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc14.sv
// Drives two accumulators (8-bit and 10-bit terms) in lockstep against a frame-level saturating-sum model.
module tb_acc14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  iLen;
    logic        iValid;
    logic [9:0]  iData10;
    logic        oReady;

    logic        ird8, ov8, os8;
    logic [13:0] od8;
    logic        ird10, ov10, os10;
    logic [13:0] od10;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc14 u_dut8 (
        .clk(clk), .rst_n(rst_n), .iLen(iLen), .iValid(iValid), .iData(iData10[7:0]),
        .iReady(ird8), .oValid(ov8), .oData(od8), .oSat(os8), .oReady(oReady)
    );

    acc14 #(.IWID(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .iLen(iLen), .iValid(iValid), .iData(iData10),
        .iReady(ird10), .oValid(ov10), .oData(od10), .oSat(os10), .oReady(oReady)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sext(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    // Reference: running sum clamped to the 14-bit signed range after every term.
    function automatic void ref_frame(input int terms[$], input int w,
                                      output int res, output int sat);
        res = 0;
        sat = 0;
        foreach (terms[i]) begin
            res = (i == 0) ? sext(terms[i], w) : res + sext(terms[i], w);
            if (res > 8191) begin
                res = 8191;
                sat = 1;
            end else if (res < -8192) begin
                res = -8192;
                sat = 1;
            end
        end
    endfunction

    task automatic check_outs(input string tag, input int e8, input int s8,
                              input int e10, input int s10);
        check_eq({tag, " oData8"}, $signed(od8), e8);
        check_eq({tag, " oSat8"}, os8, s8);
        check_eq({tag, " oData10"}, $signed(od10), e10);
        check_eq({tag, " oSat10"}, os10, s10);
    endtask

    task automatic run_frame(input string tag, input int len_in, input int terms[$],
                             input int gap_lo, input int gap_hi, input int bp);
        int e8, s8, e10, s10;
        int n;
        n = terms.size();
        ref_frame(terms, 8, e8, s8);
        ref_frame(terms, 10, e10, s10);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(gap_hi, gap_lo)) begin
                    iValid  = 1'b0;
                    iData10 = 10'($urandom);
                    iLen    = 6'($urandom);
                    @(negedge clk);
                end
            end
            iValid  = 1'b1;
            iData10 = 10'(terms[i]);
            iLen    = (i == 0) ? 6'(len_in) : 6'($urandom);
            check_eq({tag, " iReady"}, {ird8, ird10}, 2'b11);
            @(negedge clk);
            if (i < n - 1) check_eq({tag, " early oValid"}, {ov8, ov10}, 2'b00);
        end
        // Junk term stays offered through OUT; it must never be taken.
        iData10 = 10'($urandom);
        iLen    = 6'($urandom);
        check_eq({tag, " latency oValid"}, {ov8, ov10}, 2'b11);
        for (int k = 0; k < 100 && !(ov8 && ov10); k++) @(negedge clk);
        check_outs(tag, e8, s8, e10, s10);
        check_eq({tag, " OUT iReady"}, {ird8, ird10}, 2'b00);
        oReady = 1'b0;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check_eq({tag, " hold oValid"}, {ov8, ov10}, 2'b11);
            check_eq({tag, " hold iReady"}, {ird8, ird10}, 2'b00);
            check_outs({tag, " hold"}, e8, s8, e10, s10);
        end
        oReady = 1'b1;
        @(negedge clk);
        oReady = 1'b0;
        iValid = 1'b0;
        check_eq({tag, " drain oValid"}, {ov8, ov10}, 2'b00);
        check_eq({tag, " idle iReady"}, {ird8, ird10}, 2'b11);
    endtask

    function automatic void fill(ref int q[$], input int n, input int v);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int len;
        rst_n   = 1'b1;
        iLen    = '0;
        iValid  = 1'b0;
        iData10 = '0;
        oReady  = 1'b0;
        repeat (2) @(negedge clk);
        iValid = 1'b1;
        check_eq("reset oValid", {ov8, ov10}, 2'b00);
        check_eq("reset iReady", {ird8, ird10}, 2'b00);
        check_outs("reset", 0, 0, 0, 0);
        @(negedge clk);
        iValid = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_eq("release iReady", {ird8, ird10}, 2'b11);
        @(negedge clk);

        q = '{10, -3, 7, 1};
        run_frame("basic", 4, q, 0, 0, 0);
        fill(q, 63, 127);
        run_frame("pos63", 63, q, 0, 0, 1);
        fill(q, 20, 511);
        run_frame("possat", 20, q, 0, 0, 0);
        fill(q, 17, -512);
        q.push_back(100);
        run_frame("negsat", 18, q, 0, 0, 0);
        q = '{33, -71, 20};
        run_frame("bubbles", 3, q, 2, 2, 5);
        q = '{-5};
        run_frame("len0", 0, q, 0, 0, 0);
        run_frame("len1", 1, q, 0, 0, 2);

        // Reset in the middle of accumulation
        iValid = 1'b1; iLen = 6'd4; iData10 = 10'd5;
        @(negedge clk);
        iData10 = 10'd6; iLen = 6'($urandom);
        @(negedge clk);
        iValid = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check_eq("midrst oValid", {ov8, ov10}, 2'b00);
        check_eq("midrst iReady", {ird8, ird10}, 2'b00);
        check_outs("midrst", 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("midrst quiet oValid", {ov8, ov10}, 2'b00);
        end
        q = '{1, 2};
        run_frame("after_rst", 2, q, 0, 0, 0);

        // Reset while a result is pending
        iValid = 1'b1; iLen = 6'd1; iData10 = 10'd9;
        @(negedge clk);
        iValid = 1'b0;
        check_eq("outrst pre oValid", {ov8, ov10}, 2'b11);
        rst_n = 1'b1;
        #1;
        check_eq("outrst oValid", {ov8, ov10}, 2'b00);
        @(negedge clk);
        check_outs("outrst", 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("outrst quiet oValid", {ov8, ov10}, 2'b00);

        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(63, 0);
            q.delete();
            for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
                if (f % 3 == 0) q.push_back(($urandom_range(1, 0) != 0) ? 500 : -500);
                else q.push_back(int'($urandom_range(1023, 0)));
            end
            run_frame($sformatf("rand%0d", f), len, q, 0, 2, $urandom_range(3, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
